// File: rtl/zynq_packer_if.sv
// Digitizer-FIFO read port and 32-bit packet stream seen by the ZYNQ packer.
// master = packer side, slave = FIFO/ZYNQ side.
interface zynq_packer_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] FIFO_Q;
  logic             FIFO_EMPTY;
  logic             FIFO_RD;
  logic [31:0]      M_TDATA;
  logic             M_TVALID;
  logic             M_TLAST;
  logic             M_TREADY;

  modport master (
    input  FIFO_Q, FIFO_EMPTY, M_TREADY,
    output FIFO_RD, M_TDATA, M_TVALID, M_TLAST
  );

  modport slave (
    output FIFO_Q, FIFO_EMPTY, M_TREADY,
    input  FIFO_RD, M_TDATA, M_TVALID, M_TLAST
  );
endinterface

// File: rtl/zynq_packer.sv
// Frames digitizer events (header + samples) into 32-bit header/data/trailer packets; ZP_CHECKSUM_EN adds a sample XOR in the trailer.
// One FIFO read in flight, two cycles per sample; stream words are held while M_TREADY is low and no read is issued meanwhile.
module zynq_packer #(
  parameter int SIZE     = 8,
  parameter int WIDTH    = 12,
  parameter int CNT_BITS = 12
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [SIZE-1:0]     HOWMANY,
  zynq_packer_if.master       bus,
  output logic                BUSY,
  output logic                HDR_ERR,
  output logic [CNT_BITS-1:0] PKT_CNT
);

  typedef enum logic [3:0] {
    IDLE, CAP_HDR, EMIT_HDR, FETCH_LO, CAP_LO, FETCH_HI, CAP_HI, EMIT_DAT, EMIT_TRL
  } state_t;

  state_t           state_q, state_d;
  logic [SIZE-1:0]  rem_q;
  logic [WIDTH-1:0] lo_q;
  logic [31:0]      tdata_q;
  logic             tvalid_q, tlast_q;
  logic             rd_req, ld_hdr, ld_lo, ld_hi, ld_trl, drop, done;
  logic [11:0]      chk_q;
  logic [11:0]      trl_cnt;

  assign trl_cnt = 12'(PKT_CNT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!bus.FIFO_EMPTY) state_d = CAP_HDR;
      CAP_HDR:  state_d = EMIT_HDR;
      EMIT_HDR: if (bus.M_TREADY) state_d = (rem_q != '0) ? FETCH_LO : EMIT_TRL;
      FETCH_LO: if (!bus.FIFO_EMPTY) state_d = CAP_LO;
      CAP_LO:   state_d = (rem_q == SIZE'(1)) ? EMIT_DAT : FETCH_HI;
      FETCH_HI: if (!bus.FIFO_EMPTY) state_d = CAP_HI;
      CAP_HI:   state_d = EMIT_DAT;
      EMIT_DAT: if (bus.M_TREADY) state_d = (rem_q != '0) ? FETCH_LO : EMIT_TRL;
      EMIT_TRL: if (bus.M_TREADY) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_req = 1'b0;
    ld_hdr = 1'b0;
    ld_lo  = 1'b0;
    ld_hi  = 1'b0;
    ld_trl = 1'b0;
    drop   = 1'b0;
    done   = 1'b0;
    case (state_q)
      IDLE, FETCH_LO, FETCH_HI: rd_req = !bus.FIFO_EMPTY;
      CAP_HDR: ld_hdr = 1'b1;
      CAP_LO:  ld_lo  = 1'b1;
      CAP_HI:  ld_hi  = 1'b1;
      EMIT_HDR, EMIT_DAT: begin
        ld_trl = bus.M_TREADY && (rem_q == '0);
        drop   = bus.M_TREADY && (rem_q != '0);
      end
      EMIT_TRL: done = bus.M_TREADY;
      default: ;
    endcase
  end

  // Gated by reset so a non-empty FIFO is never popped while the packer is held in reset.
  assign bus.FIFO_RD  = rd_req & RST;
  assign bus.M_TDATA  = tdata_q;
  assign bus.M_TVALID = tvalid_q;
  assign bus.M_TLAST  = tlast_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      BUSY     <= 1'b0;
      HDR_ERR  <= 1'b0;
      PKT_CNT  <= '0;
      rem_q    <= '0;
      lo_q     <= '0;
    end else begin
      if (ld_hdr) begin
        rem_q    <= HOWMANY;
        BUSY     <= 1'b1;
        tdata_q  <= {8'hA5, bus.FIFO_Q[7:5], bus.FIFO_Q[4:0], 16'(HOWMANY)};
        tvalid_q <= 1'b1;
        if (bus.FIFO_Q[WIDTH-1:8] != '0) HDR_ERR <= 1'b1;
      end
      if (ld_lo) begin
        lo_q  <= bus.FIFO_Q;
        rem_q <= rem_q - SIZE'(1);
        // Odd count: last sample goes out alone with a zero high half.
        if (rem_q == SIZE'(1)) begin
          tdata_q  <= {4'hD, {WIDTH{1'b0}}, 4'h0, bus.FIFO_Q};
          tvalid_q <= 1'b1;
        end
      end
      if (ld_hi) begin
        rem_q    <= rem_q - SIZE'(1);
        tdata_q  <= {4'hD, bus.FIFO_Q, 4'h0, lo_q};
        tvalid_q <= 1'b1;
      end
      if (drop) tvalid_q <= 1'b0;
      if (ld_trl) begin
        tdata_q <= {8'h5A, chk_q, trl_cnt};
        tlast_q <= 1'b1;
      end
      if (done) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
        BUSY     <= 1'b0;
        PKT_CNT  <= PKT_CNT + CNT_BITS'(1);
      end
    end
  end

`ifdef ZP_CHECKSUM_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)               chk_q <= '0;
    else if (ld_hdr)        chk_q <= '0;
    else if (ld_lo || ld_hi) chk_q <= chk_q ^ bus.FIFO_Q[11:0];
  end
`else
  assign chk_q = '0;
`endif

endmodule

// File: tb/tb_zynq_packer.sv
// Scoreboarded bench for zynq_packer: FIFO model feeds events, a monitor checks every stream word and read-protocol rule.
module tb_zynq_packer;

  typedef struct {
    int n;
    int cyc;
  } pkt_t;

  logic        CLK;
  logic        RST;
  logic [7:0]  HOWMANY;
  logic        BUSY;
  logic        HDR_ERR;
  logic [11:0] PKT_CNT;

  zynq_packer_if #(.WIDTH(12)) bus();

  zynq_packer #(.SIZE(8), .WIDTH(12), .CNT_BITS(12)) dut (
    .CLK(CLK), .RST(RST), .HOWMANY(HOWMANY), .bus(bus),
    .BUSY(BUSY), .HDR_ERR(HDR_ERR), .PKT_CNT(PKT_CNT)
  );

  int checks = 0;
  int errors = 0;

  logic [11:0] src[$];
  int          rd_ptr = 0;
  int          wr_ptr = 0;
  logic [32:0] exp_q[$];
  pkt_t        pkt_q[$];
  int          pkts_model = 0;
  logic        hdr_err_model = 1'b0;
  int          rdy_mode = 0;
  bit          mon_en = 1'b1;

  initial begin
    CLK = 1'b0;
    forever #10 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // FIFO in normal mode: data appears the cycle after the read request.
  assign bus.FIFO_EMPTY = (rd_ptr == wr_ptr);
  always @(posedge CLK) begin
    if (bus.FIFO_RD && rd_ptr != wr_ptr) begin
      bus.FIFO_Q <= src[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // Downstream ready: 0 always, 1 random, 2 five-cycle hold per word, 3 refuse data words.
  int hold = 0;
  always begin
    @(posedge CLK);
    #1;
    case (rdy_mode)
      0: bus.M_TREADY = 1'b1;
      1: bus.M_TREADY = ($urandom_range(0, 3) != 0);
      2: begin
        if (!bus.M_TVALID) begin
          hold = 0;
          bus.M_TREADY = 1'b0;
        end else if (hold < 5) begin
          hold++;
          bus.M_TREADY = 1'b0;
        end else begin
          bus.M_TREADY = 1'b1;
        end
      end
      default: bus.M_TREADY = !(bus.M_TVALID && bus.M_TDATA[31:28] == 4'hD);
    endcase
  end

  int          cyc = 0;
  int          t0 = 0;
  int          rd_cnt = 0;
  bit          prev_rd = 1'b0;
  bit          have_hold = 1'b0;
  logic [31:0] hold_dat = '0;
  always @(negedge CLK) begin
    logic [32:0] e;
    pkt_t        p;
    cyc++;
    if (!RST) begin
      rd_cnt    = 0;
      have_hold = 1'b0;
      prev_rd   = 1'b0;
    end else begin
      if (bus.FIFO_RD) begin
        check("fifo_rd_legal",
              32'(!bus.FIFO_EMPTY && !prev_rd && !(bus.M_TVALID && !bus.M_TREADY)), 32'd1);
        if (!BUSY) t0 = cyc;
        else       rd_cnt++;
      end
      if (have_hold) begin
        check("tvalid_held", 32'(bus.M_TVALID), 32'd1);
        check("tdata_stable", bus.M_TDATA, hold_dat);
      end
      have_hold = bus.M_TVALID && !bus.M_TREADY;
      hold_dat  = bus.M_TDATA;
      if (bus.M_TVALID && bus.M_TREADY && mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word actual=%h required=none", bus.M_TDATA);
        end else begin
          e = exp_q.pop_front();
          check("tdata", bus.M_TDATA, e[31:0]);
          check("tlast", 32'(bus.M_TLAST), 32'(e[32]));
          if (e[32] && pkt_q.size() != 0) begin
            p = pkt_q.pop_front();
            check("rd_count", rd_cnt, p.n);
            if (p.cyc != 0) check("pkt_cycles", cyc - t0 + 1, p.cyc);
            rd_cnt = 0;
          end
        end
      end
      prev_rd = bus.FIFO_RD;
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() != 0 || BUSY) && t < 3000) begin
      step();
      t++;
    end
    if (t >= 3000) fail("packet_done");
  endtask

  // Reference packet built straight from the framing rules, then the event is fed to the FIFO.
  task automatic send_pkt(input logic [11:0] hdr, input logic [11:0] smp[$], input int gap,
                          input int cyc_exp);
    int          n;
    int          t;
    logic [11:0] chk;
    logic [11:0] hi;
    pkt_t        p;
    n = smp.size();
    exp_q.push_back({1'b0, 8'hA5, hdr[7:0], 16'(n)});
    for (int i = 0; i < n; i += 2) begin
      hi = (i + 1 < n) ? smp[i+1] : 12'h000;
      exp_q.push_back({1'b0, 4'hD, hi, 4'h0, smp[i]});
    end
    chk = 12'h000;
`ifdef ZP_CHECKSUM_EN
    foreach (smp[i]) chk = chk ^ smp[i];
`endif
    exp_q.push_back({1'b1, 8'h5A, chk, 12'(pkts_model)});
    pkts_model++;
    if (hdr[11:8] != 4'h0) hdr_err_model = 1'b1;
    p.n   = n;
    p.cyc = cyc_exp;
    pkt_q.push_back(p);

    step();
    HOWMANY = 8'(n);
    src.push_back(hdr);
    foreach (smp[i]) src.push_back(smp[i]);
    wr_ptr += (gap < 0) ? 1 + n : 1 + gap;
    t = 0;
    while (!BUSY && t < 100) begin
      step();
      t++;
    end
    if (!BUSY) fail("busy_rise");
    HOWMANY = 8'($urandom);
    if (gap >= 0) begin
      t = 0;
      while (rd_ptr != wr_ptr && t < 200) begin
        step();
        t++;
      end
      if (rd_ptr != wr_ptr) fail("gap_drain");
      repeat (10) begin
        step();
        check("busy_in_gap", 32'(BUSY), 32'd1);
      end
      wr_ptr += n - gap;
    end
    wait_done();
    check("hdr_err", 32'(HDR_ERR), 32'(hdr_err_model));
    check("pkt_cnt", 32'(PKT_CNT), 32'(12'(pkts_model)));
    check("busy_after", 32'(BUSY), 32'd0);
  endtask

  initial begin
    logic [11:0] smp[$];
    int          n;
    int          gap;
    int          t;
    RST     = 1'b0;
    HOWMANY = '0;
    repeat (3) step();
    check("rst_tdata", bus.M_TDATA, 32'h0);
    check("rst_tvalid", 32'(bus.M_TVALID), 32'd0);
    check("rst_tlast", 32'(bus.M_TLAST), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_hdr_err", 32'(HDR_ERR), 32'd0);
    check("rst_pkt_cnt", 32'(PKT_CNT), 32'd0);
    RST = 1'b1;
    repeat (20) begin
      step();
      check("idle_no_rd", 32'(bus.FIFO_RD), 32'd0);
      check("idle_tvalid", 32'(bus.M_TVALID), 32'd0);
    end

    smp = {12'h001, 12'h002, 12'h003, 12'h004};
    send_pkt(12'h0A3, smp, -1, 14);
    smp = {12'hFFF, 12'h001, 12'h800};
    send_pkt(12'h0A3, smp, -1, 3 + 6 + 2 + 1);
    smp.delete();
    send_pkt(12'h041, smp, -1, 4);

    rdy_mode = 2;
    smp = {12'h001, 12'h002, 12'h003, 12'h004};
    send_pkt(12'h0A3, smp, -1, 0);
    rdy_mode = 0;
    send_pkt(12'h0A3, smp, 2, 0);
    smp = {12'h123, 12'h456};
    send_pkt(12'h8A3, smp, -1, 0);

    rdy_mode = 1;
    for (int k = 0; k < 24; k++) begin
      n = $urandom_range(0, 17);
      smp.delete();
      for (int i = 0; i < n; i++) smp.push_back(12'($urandom));
      gap = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      send_pkt({4'h0, 8'($urandom)}, smp, gap, 0);
    end

    // Reset while a data word is stalled on the stream; the FIFO is already drained.
    rdy_mode = 3;
    mon_en   = 1'b0;
    step();
    HOWMANY = 8'd4;
    src.push_back(12'h0A3);
    src.push_back(12'h001);
    src.push_back(12'h002);
    wr_ptr += 3;
    t = 0;
    while (!(bus.M_TVALID && bus.M_TDATA[31:28] == 4'hD) && t < 100) begin
      step();
      t++;
    end
    check("pre_rst_data", bus.M_TDATA, 32'hD002_0001);
    RST = 1'b0;
    #1;
    check("mid_rst_tvalid", 32'(bus.M_TVALID), 32'd0);
    check("mid_rst_tdata", bus.M_TDATA, 32'h0);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_hdr_err", 32'(HDR_ERR), 32'd0);
    check("mid_rst_pkt_cnt", 32'(PKT_CNT), 32'd0);
    check("mid_rst_rd", 32'(bus.FIFO_RD), 32'd0);
    exp_q.delete();
    pkt_q.delete();
    pkts_model    = 0;
    hdr_err_model = 1'b0;
    repeat (2) step();
    RST      = 1'b1;
    rdy_mode = 0;
    mon_en   = 1'b1;
    repeat (3) step();
    check("post_rst_tvalid", 32'(bus.M_TVALID), 32'd0);
    smp = {12'h001, 12'h002, 12'h003, 12'h004};
    send_pkt(12'h0A3, smp, -1, 14);

    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/zynq_packer.md
Name: zynq_packer

Overview:
- Downstream of the multi-channel digitizer's output FIFO.
- Pops the collated 12-bit stream from that FIFO: one header word {SEL,BC}, then `howmany` samples per triggered event.
- Frames each event as a 32-bit packet (header, packed sample pairs, trailer) on a valid/ready stream towards the ZYNQ.
- Drives the FIFO read request that the digitizer exposes as ZYNQ_RD_REQUEST.

Parameters:
- SIZE, 8, width of `howmany` / sample-count fields (must be ≤16)
- WIDTH, 12, width of FIFO data word and of one sample
- CNT_BITS, 12, width of the packet sequence counter

Ports:
- CLK  in  1  system clock (50 MHz domain, same clock as the digitizer FIFO)
- RST  in  1  reset, asynchronous, active-low
- HOWMANY  in  SIZE  samples per event; latched at header capture
- FIFO_Q  in  WIDTH  FIFO read data; normal (non-show-ahead) mode, valid the cycle after FIFO_RD
- FIFO_EMPTY  in  1  FIFO empty flag
- FIFO_RD  out  1  FIFO read request (connects to ZYNQ_RD_REQUEST)
- M_TDATA  out  32  packet word
- M_TVALID  out  1  M_TDATA valid
- M_TLAST  out  1  marks trailer word
- M_TREADY  in  1  downstream accept
- BUSY  out  1  high from header pop until trailer accepted
- HDR_ERR  out  1  sticky: header word had FIFO_Q[11:8]≠0
- PKT_CNT  out  CNT_BITS  packets completed

Behaviour:
- Reset (RST=0, async): M_TDATA=0, M_TVALID=0, M_TLAST=0, FIFO_RD=0, BUSY=0, HDR_ERR=0, PKT_CNT=0, checksum=0, state=IDLE.
- A mid-packet reset drops the partial packet. FIFO contents are not touched.
- FIFO_RD rules:
  - Asserted for exactly one cycle, only when FIFO_EMPTY=0.
  - At most one read in flight.
  - FIFO_Q is captured in the cycle after FIFO_RD.
  - FIFO_RD is never asserted while M_TVALID=1 and M_TREADY=0.
- States:
  - IDLE: if !FIFO_EMPTY, assert FIFO_RD and go to CAP_HDR.
  - CAP_HDR:
    - Latch chan=FIFO_Q[7:5], bc=FIFO_Q[4:0], n=HOWMANY.
    - Set HDR_ERR if FIFO_Q[11:8]≠0.
    - Set BUSY=1; go to EMIT_HDR.
  - EMIT_HDR:
    - M_TDATA={8'hA5, chan, bc, 16'(n)}, M_TVALID=1.
    - On M_TREADY: go to FETCH_LO if n≠0, else EMIT_TRL.
  - FETCH_LO: wait for !FIFO_EMPTY, pulse FIFO_RD, go to CAP_LO.
  - CAP_LO:
    - lo=FIFO_Q; remaining n decremented.
    - If remaining=0: go to EMIT_DAT with hi=0 (odd count).
    - Else go to FETCH_HI.
  - FETCH_HI / CAP_HI: same as FETCH_LO / CAP_LO, capturing hi. Then go to EMIT_DAT.
  - EMIT_DAT:
    - M_TDATA={4'hD, hi, 4'h0, lo}, M_TVALID=1.
    - On M_TREADY: go to FETCH_LO if remaining≠0, else EMIT_TRL.
  - EMIT_TRL:
    - M_TDATA={8'h5A, chk[11:0], PKT_CNT[11:0] zero-extended/truncated}, M_TVALID=1, M_TLAST=1.
    - On M_TREADY: PKT_CNT+1 (wraps modulo 2^CNT_BITS), BUSY=0, go to IDLE.
- Stream rules:
  - M_TDATA/M_TVALID/M_TLAST are registered.
  - Held stable while M_TVALID=1 and M_TREADY=0.
  - M_TVALID drops the cycle after acceptance unless the next word is already formed.
- FIFO empty mid-packet: stall in FETCH_* indefinitely. No timeout, no padding.
- HOWMANY changes mid-packet: ignored until the next header.
- Odd n: last data word carries hi=0. Data word count = ceil(n/2).
- Minimum packet cycle count with M_TREADY=1: 3 + 2·n + ceil(n/2) + 1.

Optional Feature:
- Macro: ZP_CHECKSUM_EN.
- Defined:
  - chk = XOR of every sample captured in the packet.
  - chk is cleared in CAP_HDR.
  - Odd-count padding does not contribute.
- Undefined: trailer bits [23:12]=0 and there is no checksum logic.

Test Plan:
- Reset, FIFO_EMPTY=1, M_TREADY=1 → all outputs 0; FIFO_RD never asserts.
- Header 12'h0A3 (chan 5, bc 3), HOWMANY=4, samples 1,2,3,4 → packet:
  - 32'hA5A3_0004
  - 32'hD002_0001
  - 32'hD004_0003
  - trailer 32'h5A00_4000 with M_TLAST=1 (chk=1^2^3^4=4 with ZP_CHECKSUM_EN; 32'h5A00_0000 without)
  - PKT_CNT → 1.
- HOWMANY=3, samples 12'hFFF, 12'h001, 12'h800:
  - Second data word = 32'hD000_0800.
  - Trailer chk = 12'h7FE.
- HOWMANY=0 → header 32'hA5xx_0000 immediately followed by trailer; no FIFO_RD between them.
- M_TREADY held low for 5 cycles on header and on each data word → M_TDATA stable; no FIFO_RD while stalled; packet identical to the unstalled run.
- Check each of the following:
  - FIFO_EMPTY asserted for 10 cycles between samples 2 and 3 → BUSY stays 1 and the packet completes correctly.
  - Header 12'h8A3 → HDR_ERR=1 and stays 1 until reset.
  - RST pulsed low mid-data → M_TVALID=0 and state IDLE immediately.
